// File: rtl/jam_pkg.sv
// Shared definitions for the job-assignment datapath: sizes, widths and the
// cost-table state encoding. The enumerator block imports this package too.
package jam_pkg;

  localparam int N   = 8;
  localparam int CW  = 7;
  localparam int LBW = 10;
  localparam int SW  = 13;
  localparam int AW  = $clog2(N);
  localparam int TAW = 2 * AW;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  function automatic logic [CW-1:0] cost_min(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return (b < a) ? b : a;
  endfunction

endpackage

// File: rtl/jam_cost_ram.sv
// N*N x CW cost register file: one write port, one registered read port.
// A read cycle with rd_en low returns zero, so downstream sees zeros
// until the table is usable.
module jam_cost_ram
  import jam_pkg::*;
(
  input  logic           CLK,
  input  logic           RST,
  input  logic           we,
  input  logic [TAW-1:0] wr_addr,
  input  logic [CW-1:0]  wr_data,
  input  logic           rd_en,
  input  logic [TAW-1:0] rd_addr,
  output logic [CW-1:0]  rd_data
);

  logic [CW-1:0] mem [N*N];

  // Storage write; contents are deliberately not cleared by reset.
  always_ff @(posedge CLK) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Registered read, forced to zero when reads are not enabled.
  always_ff @(posedge CLK) begin
    if (RST || !rd_en) rd_data <= '0;
    else               rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/jam_cost_table.sv
// Cost store: accepts a row-major serial load of the cost matrix, tracks the
// sum of row minima and a checksum during the load, then serves (W,J)
// lookups with one cycle of registered latency.
//
//  state    | meaning
//  ---------+--------------------------------------------------
//  ST_EMPTY | nothing loaded, waiting for beat 0
//  ST_LOAD  | partial load in progress, cnt = next beat index
//  ST_READY | full table held, lookups served, load stream ignored
module jam_cost_table
  import jam_pkg::*;
(
  input  logic           CLK,
  input  logic           RST,
  input  logic           ld_valid,
  output logic           ld_ready,
  input  logic [CW-1:0]  ld_data,
  input  logic           clr,
  input  logic [AW-1:0]  W,
  input  logic [AW-1:0]  J,
  output logic [CW-1:0]  Cost,
  output logic           TableReady,
  output logic [LBW-1:0] LowerBound,
  output logic [SW-1:0]  CheckSum
);

  localparam logic [TAW-1:0] LAST_BEAT = TAW'(N * N - 1);
  localparam logic [AW-1:0]  LAST_J    = AW'(N - 1);

  state_t         state, next_state;
  logic [TAW-1:0] cnt;
  logic [CW-1:0]  row_min;
  logic [CW-1:0]  cur_min;
  logic [AW-1:0]  beat_j;
  logic           accept;

  assign accept  = ld_valid && ld_ready;
  assign beat_j  = cnt[AW-1:0];
  // Running minimum including the current beat; first beat of a row restarts it.
  assign cur_min = (beat_j == '0) ? ld_data : cost_min(row_min, ld_data);

  // State register; clr behaves like reset.
  always_ff @(posedge CLK) begin
    if (RST || clr) state <= ST_EMPTY;
    else            state <= next_state;
  end

  // Next-state and handshake/status outputs.
  always_comb begin
    next_state = state;
    ld_ready   = 1'b0;
    TableReady = 1'b0;
    case (state)
      ST_EMPTY: begin
        ld_ready = 1'b1;
        if (ld_valid) next_state = (cnt == LAST_BEAT) ? ST_READY : ST_LOAD;
      end
      ST_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid && cnt == LAST_BEAT) next_state = ST_READY;
      end
      ST_READY: begin
        TableReady = 1'b1;
      end
      default: next_state = ST_EMPTY;
    endcase
  end

  // Beat counter, row minimum and the two accumulators; all restart on EMPTY entry.
  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      cnt        <= '0;
      row_min    <= '0;
      LowerBound <= '0;
      CheckSum   <= '0;
    end else if (accept) begin
      cnt      <= cnt + 1'b1;
      row_min  <= cur_min;
      CheckSum <= CheckSum + SW'(ld_data);
      if (beat_j == LAST_J) LowerBound <= LowerBound + LBW'(cur_min);
    end
  end

  jam_cost_ram u_ram (
    .CLK     (CLK),
    .RST     (RST),
    .we      (accept),
    .wr_addr (cnt),
    .wr_data (ld_data),
    .rd_en   ((state == ST_READY) && !clr),
    .rd_addr ({W, J}),
    .rd_data (Cost)
  );

endmodule

// File: tb/tb_jam_cost_table.sv
// Bench for jam_cost_table: table of load scenarios with expected bound and
// checksum, a lookup scoreboard, and hand-written abort / ignore / clear steps.
module tb_jam_cost_table;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ld_valid;
  logic        ld_ready;
  logic [6:0]  ld_data;
  logic        clr;
  logic [2:0]  W;
  logic [2:0]  J;
  logic [6:0]  Cost;
  logic        TableReady;
  logic [9:0]  LowerBound;
  logic [12:0] CheckSum;

  jam_cost_table dut (
    .CLK        (CLK),
    .RST        (RST),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .clr        (clr),
    .W          (W),
    .J          (J),
    .Cost       (Cost),
    .TableReady (TableReady),
    .LowerBound (LowerBound),
    .CheckSum   (CheckSum)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int kind;
    bit gap;
    bit abort;
    int exp_lb;
    int exp_cs;
  } vec_t;

  vec_t vecs[5];
  int   model[64];
  int   exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // kind 0: ramp w*8+j; 1: all 127; 2: all 1; 3: min in middle column (j==4 -> w, else 100+w)
  function automatic int cost_of(input int kind, input int k);
    int w, j;
    w = k / 8;
    j = k % 8;
    case (kind)
      0:       return w * 8 + j;
      1:       return 127;
      2:       return 1;
      default: return (j == 4) ? w : 100 + w;
    endcase
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input int kind, input bit gap);
    int ready_err = 0;
    int early_tr  = 0;
    int cost_err  = 0;
    for (int k = 0; k < 64; k++) begin
      ld_valid = 1'b1;
      ld_data  = 7'(cost_of(kind, k));
      model[k] = cost_of(kind, k);
      if (ld_ready !== 1'b1) ready_err++;
      if (TableReady !== 1'b0) early_tr++;
      if (Cost !== 7'd0) cost_err++;
      tick();
      if (gap && k != 63) begin
        ld_valid = 1'b0;
        ld_data  = 7'h7f;
        if (ld_ready !== 1'b1) ready_err++;
        if (TableReady !== 1'b0) early_tr++;
        tick();
      end
    end
    ld_valid = 1'b0;
    chk("ld_ready_during_load", ready_err, 0);
    chk("table_ready_early", early_tr, 0);
    chk("cost_zero_before_ready", cost_err, 0);
    chk("table_ready_after_last", int'(TableReady), 1);
    chk("ld_ready_after_last", int'(ld_ready), 0);
  endtask

  task automatic sweep();
    for (int a = 0; a < 64; a++) begin
      W = 3'(a / 8);
      J = 3'(a % 8);
      exp_q.push_back(model[a]);
      tick();
      chk($sformatf("lookup_%0d", a), int'(Cost), exp_q.pop_front());
    end
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    vecs[0] = '{kind: 0, gap: 1'b0, abort: 1'b0, exp_lb: 224,  exp_cs: 2016};
    vecs[1] = '{kind: 1, gap: 1'b0, abort: 1'b0, exp_lb: 1016, exp_cs: 8128};
    vecs[2] = '{kind: 0, gap: 1'b1, abort: 1'b0, exp_lb: 224,  exp_cs: 2016};
    vecs[3] = '{kind: 2, gap: 1'b0, abort: 1'b1, exp_lb: 8,    exp_cs: 64};
    vecs[4] = '{kind: 3, gap: 1'b1, abort: 1'b0, exp_lb: 28,   exp_cs: 5824};

    RST = 1'b1; clr = 1'b0; ld_valid = 1'b0; ld_data = '0; W = '0; J = '0;
    tick();
    tick();
    RST = 1'b0;
    chk("rst_ld_ready", int'(ld_ready), 1);
    chk("rst_table_ready", int'(TableReady), 0);
    chk("rst_cost", int'(Cost), 0);
    chk("rst_lower_bound", int'(LowerBound), 0);
    chk("rst_checksum", int'(CheckSum), 0);

    for (int v = 0; v < 5; v++) begin
      if (vecs[v].abort) begin
        for (int k = 0; k < 30; k++) begin
          ld_valid = 1'b1;
          ld_data  = 7'(cost_of(0, k) + 50);
          tick();
        end
        ld_valid = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("abort_lower_bound", int'(LowerBound), 0);
        chk("abort_checksum", int'(CheckSum), 0);
        chk("abort_ld_ready", int'(ld_ready), 1);
        chk("abort_table_ready", int'(TableReady), 0);
      end

      load(vecs[v].kind, vecs[v].gap);
      chk($sformatf("lower_bound_v%0d", v), int'(LowerBound), vecs[v].exp_lb);
      chk($sformatf("checksum_v%0d", v), int'(CheckSum), vecs[v].exp_cs);

      if (v == 0) begin
        W = 3'd3; J = 3'd5;
        exp_q.push_back(29);
        tick();
        chk("lookup_w3_j5", int'(Cost), exp_q.pop_front());
      end
      sweep();

      begin
        int ignored_ready = 0;
        for (int e = 0; e < 10; e++) begin
          ld_valid = 1'b1;
          ld_data  = 7'h55;
          if (ld_ready !== 1'b0) ignored_ready++;
          tick();
        end
        ld_valid = 1'b0;
        chk("ready_ignores_ld_ready", ignored_ready, 0);
      end
      chk("ready_ignores_lb", int'(LowerBound), vecs[v].exp_lb);
      chk("ready_ignores_cs", int'(CheckSum), vecs[v].exp_cs);
      chk("ready_stays", int'(TableReady), 1);
      sweep();

      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_table_ready", int'(TableReady), 0);
      chk("clr_cost", int'(Cost), 0);
      chk("clr_ld_ready", int'(ld_ready), 1);
      chk("clr_lower_bound", int'(LowerBound), 0);
      chk("clr_checksum", int'(CheckSum), 0);
      tick();
      chk("empty_cost_zero", int'(Cost), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
